// File: rtl/sc_ticktimer.sv
// Dual-channel tick timer with sticky active-low terminal flags for the
// background shift/display state machine.
// Latency: a flag falls on the clock after the lim-th event on its channel,
// and rises on that channel's next event or on a synchronous clear.
// No backpressure: requests are consumed one per cycle, and events are never queued or dropped.
//
// Ports:
//   SC_TICKTIMER_CLOCK_50        system clock
//   SC_TICKTIMER_RESET_InHigh    asynchronous reset, active high
//   SC_TICKTIMER_clear_InLow     synchronous clear of counters/flags; reloads level
//   SC_TICKTIMER_upcount0_InLow  channel-0 count request (lane shift period)
//   SC_TICKTIMER_upcount1_InLow  channel-1 count request (display refresh period)
//   SC_TICKTIMER_level_In        speed level 0..3, divides the channel-0 period by 2^level
//   SC_TICKTIMER_T0_OutLow       channel-0 terminal flag, sticky, active low
//   SC_TICKTIMER_T1_OutLow       channel-1 terminal flag, sticky, active low
//   SC_TICKTIMER_count0_Out      channel-0 counter value (debug)
//
// Optional build macro SC_TICKTIMER_PRESCALE_EN: adds a free-running
// prescaler.  A request then counts only on a cycle where the prescaler
// reaches PRESCALE-1.  Without the macro, every cycle with a low request is an event.

module sc_ticktimer #(
  parameter int                CNT_W       = 8,
  parameter logic [CNT_W-1:0]  LIMIT0_BASE = CNT_W'(64),
  parameter logic [CNT_W-1:0]  LIMIT1      = CNT_W'(16),
  parameter int                PRESCALE    = 4
) (
  input  logic             SC_TICKTIMER_CLOCK_50,
  input  logic             SC_TICKTIMER_RESET_InHigh,
  input  logic             SC_TICKTIMER_clear_InLow,
  input  logic             SC_TICKTIMER_upcount0_InLow,
  input  logic             SC_TICKTIMER_upcount1_InLow,
  input  logic [1:0]       SC_TICKTIMER_level_In,
  output logic             SC_TICKTIMER_T0_OutLow,
  output logic             SC_TICKTIMER_T1_OutLow,
  output logic [CNT_W-1:0] SC_TICKTIMER_count0_Out
);

  typedef enum logic {
    COUNTING = 1'b0,
    EXPIRED  = 1'b1
  } ch_state_t;

  logic             clk;
  logic             rst;
  logic             clear;
  logic             ev0;
  logic             ev1;

  assign clk   = SC_TICKTIMER_CLOCK_50;
  assign rst   = SC_TICKTIMER_RESET_InHigh;
  assign clear = ~SC_TICKTIMER_clear_InLow;

  // ------------------------------------------------------------------
  // Event qualification
  // ------------------------------------------------------------------
`ifdef SC_TICKTIMER_PRESCALE_EN
  localparam int PS_N = (PRESCALE < 1) ? 1 : PRESCALE;
  localparam int PS_W = (PS_N > 1) ? $clog2(PS_N) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PS_N - 1);

  logic [PS_W-1:0] ps_q;
  logic            ps_tick;

  assign ps_tick = (ps_q == PS_LAST);

  // Free-running; clear realigns it so the first period after a clear is full length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_q <= '0;
    end else if (clear) begin
      ps_q <= '0;
    end else if (ps_tick) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_q + PS_W'(1);
    end
  end

  assign ev0 = ~SC_TICKTIMER_upcount0_InLow & ps_tick;
  assign ev1 = ~SC_TICKTIMER_upcount1_InLow & ps_tick;
`else
  assign ev0 = ~SC_TICKTIMER_upcount0_InLow;
  assign ev1 = ~SC_TICKTIMER_upcount1_InLow;
`endif

  // ------------------------------------------------------------------
  // Effective limits
  // ------------------------------------------------------------------
  logic [1:0]       lvl_q;
  logic [CNT_W-1:0] lim0_raw;
  logic [CNT_W-1:0] lim0;
  logic [CNT_W-1:0] lim0_m1;
  logic [CNT_W-1:0] lim1_m1;

  localparam logic [CNT_W-1:0] LIM1_EFF = (LIMIT1 == '0) ? CNT_W'(1) : LIMIT1;

  assign lim0_raw = LIMIT0_BASE >> lvl_q;
  assign lim0     = (lim0_raw == '0) ? CNT_W'(1) : lim0_raw;
  // lim0 and LIM1_EFF are both >= 1, so these never underflow.
  assign lim0_m1  = lim0 - CNT_W'(1);
  assign lim1_m1  = LIM1_EFF - CNT_W'(1);

  // ------------------------------------------------------------------
  // Channel 0: lane shift period, scaled by the latched level
  // ------------------------------------------------------------------
  logic [CNT_W-1:0] count0;
  logic             t0_q;
  ch_state_t        st0;

  // In EXPIRED the counter is always 0 and the limit is fixed, because lvl_q
  // only moves on a wrap or a clear.  The releasing event is the first event of
  // the new period.  With a limit of 1 it leaves the counter at 0 rather than
  // re-expiring in the same cycle.  The flag therefore always shows a high phase
  // between terminal counts, which the downstream CHECK state relies on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count0 <= '0;
      t0_q   <= 1'b1;
      st0    <= COUNTING;
      lvl_q  <= 2'd0;
    end else if (clear) begin
      count0 <= '0;
      t0_q   <= 1'b1;
      st0    <= COUNTING;
      lvl_q  <= SC_TICKTIMER_level_In;
    end else if (ev0) begin
      case (st0)
        EXPIRED: begin
          count0 <= (lim0_m1 == '0) ? '0 : CNT_W'(1);
          t0_q   <= 1'b1;
          st0    <= COUNTING;
        end
        default: begin
          // >= rather than ==: the limit may already be below the count.
          if (count0 >= lim0_m1) begin
            count0 <= '0;
            t0_q   <= 1'b0;
            st0    <= EXPIRED;
            lvl_q  <= SC_TICKTIMER_level_In;
          end else begin
            count0 <= count0 + CNT_W'(1);
            t0_q   <= 1'b1;
            st0    <= COUNTING;
          end
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Channel 1: display refresh period, fixed limit
  // ------------------------------------------------------------------
  logic [CNT_W-1:0] count1;
  logic             t1_q;
  ch_state_t        st1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count1 <= '0;
      t1_q   <= 1'b1;
      st1    <= COUNTING;
    end else if (clear) begin
      count1 <= '0;
      t1_q   <= 1'b1;
      st1    <= COUNTING;
    end else if (ev1) begin
      case (st1)
        EXPIRED: begin
          count1 <= (lim1_m1 == '0) ? '0 : CNT_W'(1);
          t1_q   <= 1'b1;
          st1    <= COUNTING;
        end
        default: begin
          if (count1 >= lim1_m1) begin
            count1 <= '0;
            t1_q   <= 1'b0;
            st1    <= EXPIRED;
          end else begin
            count1 <= count1 + CNT_W'(1);
            t1_q   <= 1'b1;
            st1    <= COUNTING;
          end
        end
      endcase
    end
  end

  assign SC_TICKTIMER_T0_OutLow  = t0_q;
  assign SC_TICKTIMER_T1_OutLow  = t1_q;
  assign SC_TICKTIMER_count0_Out = count0;

endmodule

// File: doc/sc_ticktimer.md
Name: sc_ticktimer

Overview:
- Dual-channel tick timer directly upstream of the background shift/display state machine.
- Consumes its active-low count requests, upcount0_InLow (driven by COUNT_0) and upcount1_InLow (driven by COUNT_1).
- Returns active-low sticky terminal flags T0_OutLow and T1_OutLow, which the FSM samples in its CHECK states.
- Channel 0 sets the lane shift period; a 2-bit speed level scales it. Channel 1 sets the display refresh period.

Parameters:
- CNT_W, 8, width of both event counters.
- LIMIT0_BASE, 8'd64, channel-0 period in events at level 0.
- LIMIT1, 8'd16, channel-1 period in events (fixed).
- PRESCALE, 4, cycles per prescaler tick; used only with SC_TICKTIMER_PRESCALE_EN.

Ports:
- SC_TICKTIMER_CLOCK_50  in  1  system clock.
- SC_TICKTIMER_RESET_InHigh  in  1  asynchronous active-high reset.
- SC_TICKTIMER_clear_InLow  in  1  synchronous clear of counters and flags, active low.
- SC_TICKTIMER_upcount0_InLow  in  1  channel-0 count request, active low.
- SC_TICKTIMER_upcount1_InLow  in  1  channel-1 count request, active low.
- SC_TICKTIMER_level_In  in  2  speed level, 0 (slowest) to 3.
- SC_TICKTIMER_T0_OutLow  out  1  channel-0 terminal flag, active low, sticky.
- SC_TICKTIMER_T1_OutLow  out  1  channel-1 terminal flag, active low, sticky.
- SC_TICKTIMER_count0_Out  out  CNT_W  channel-0 counter value, for debug and verification.

Behaviour:
- One clock domain. Reset is asynchronous and active-high. All state is registered; no combinational input-to-output path.
- Reset values:
  - count0 = 0, count1 = 0.
  - T0_OutLow = 1, T1_OutLow = 1.
  - latched level lvl_q = 0.
- Effective limits:
  - lim0 = LIMIT0_BASE >> lvl_q; if the result is 0, lim0 = 1.
  - lim1 = LIMIT1; if 0, lim1 = 1.
- Per-channel state machine, channel n, states COUNTING and EXPIRED, evaluated each clock in this priority order:
  1. clear_InLow == 0: counter = 0, flag = 1, state COUNTING. Channel 0 also reloads lvl_q from level_In. Clear overrides any simultaneous count request.
  2. Count event (upcount_n_InLow == 0) with count_n >= lim_n - 1: counter = 0, flag = 0, state EXPIRED. Channel 0 also reloads lvl_q.
  3. Count event otherwise: counter = counter + 1 and flag = 1. An event in EXPIRED therefore releases the flag and returns to COUNTING.
  4. No event: hold counter, flag and state.
- Latency and handshake:
  - The flag falls on the clock after the lim-th event and stays low until the next event on that channel, or a clear.
  - This guarantees the FSM sees the flag in its CHECK state one cycle after COUNT, whatever path it took.
- The >= compare (not ==) handles a limit that drops below the current count after a level change: the channel wraps on the next event, with no wrap-around through 2^CNT_W.
- level_In is sampled only on channel-0 wrap or on clear. Mid-period changes never shorten the period already in progress.
- Channels are fully independent. Simultaneous wraps on both channels in one cycle drive both flags low in the same cycle.
- The counter never exceeds lim - 1. Increments use CNT_W-bit arithmetic and never overflow.
- Reset asserted mid-period returns all state to reset values immediately; any pending flag is lost.

Optional Feature:
- Macro SC_TICKTIMER_PRESCALE_EN.
- When defined:
  - A free-running prescaler counts 0..PRESCALE-1 and wraps.
  - A count event is qualified as upcount_n_InLow == 0 AND prescaler == PRESCALE-1.
  - Clear resets the prescaler to 0. Reset sets it to 0.
- When undefined: no prescaler logic; every cycle with the request low is an event.

Test Plan (LIMIT0_BASE=8, LIMIT1=4, PRESCALE=4, macro undefined unless stated):
- Reset, then upcount0 low for 8 cycles with level=0 -> T0 goes low exactly on cycle 9; count0 = 0. Raise upcount0 and wait 5 cycles -> T0 stays low. One more upcount0 pulse -> T0 = 1 next cycle, count0 = 1.
- level=2 applied via clear, then upcount0 held low -> T0 falls after every 2 events. level=3 -> lim0 = 1, so T0 alternates low/high on each event while the request is held.
- count0 = 6 at level 0, then level_In set to 3 -> no effect until wrap. Change latched via clear while count0 = 6 with level 3 -> count0 = 0; next event expires immediately.
- upcount0 and upcount1 both low, 8 cycles -> T1 low after events 4 and 8, toggled high by event 5. T0 and T1 both low after cycle 8.
- clear_InLow low together with the 8th upcount0 event -> count0 = 0 and T0 = 1. Reset pulsed while T1 low -> T1 = 1 asynchronously.
- With SC_TICKTIMER_PRESCALE_EN defined and upcount1 held low -> T1 falls after 16 cycles, then every 16 cycles thereafter.
